// File: rtl/hazard_sequencer_if.sv
// Hazard sequencer bundle: ID/EX/MEM observation inputs and the
// pipeline write-enable, bubble and flush controls.
interface hazard_sequencer_if;
    logic [5:0] id_opcode;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_memread;
    logic [4:0] ex_rt;
    logic       mem_branch_taken;
    logic       mem_busy;
    logic       pc_write;
    logic       ifid_write;
    logic       idex_write;
    logic       exmem_write;
    logic       ctrl_bubble;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic       stall_active;

    modport master (
        output id_opcode, id_rs, id_rt, ex_memread, ex_rt, mem_branch_taken, mem_busy,
        input  pc_write, ifid_write, idex_write, exmem_write, ctrl_bubble,
               ifid_flush, idex_flush, exmem_flush, stall_active
    );

    modport slave (
        input  id_opcode, id_rs, id_rt, ex_memread, ex_rt, mem_branch_taken, mem_busy,
        output pc_write, ifid_write, idex_write, exmem_write, ctrl_bubble,
               ifid_flush, idex_flush, exmem_flush, stall_active
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Load-use stall, taken-branch flush and memory-busy freeze controller for the 5-stage core.
// Optional stall/flush performance counters are enabled by HAZARD_PERF_CNT_EN.
module hazard_sequencer #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_sequencer_if.slave   hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
`endif
);

    if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 7) begin : g_bad_stall
        $error("LOAD_STALL_CYCLES must be in 1..7");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("CNT_W must be at least 1");
    end

    typedef enum logic {RUN, LOAD_STALL} state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_rem, w_rem_nxt;
    logic       w_uses_rt;
    logic       w_load_use;

    always_comb begin
        w_uses_rt = 1'b0;
        case (hz.id_opcode)
            6'b000000, 6'b101011, 6'b000100: w_uses_rt = 1'b1;
            default:                         w_uses_rt = 1'b0;
        endcase
    end

    assign w_load_use = hz.ex_memread && (hz.ex_rt != '0) &&
                        ((hz.ex_rt == hz.id_rs) || ((hz.ex_rt == hz.id_rt) && w_uses_rt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_rem_nxt        = r_rem;
        hz.pc_write      = 1'b1;
        hz.ifid_write    = 1'b1;
        hz.idex_write    = 1'b1;
        hz.exmem_write   = 1'b1;
        hz.ctrl_bubble   = 1'b0;
        hz.ifid_flush    = 1'b0;
        hz.idex_flush    = 1'b0;
        hz.exmem_flush   = 1'b0;
        hz.stall_active  = (r_state == LOAD_STALL);
        if (rst) begin
            hz.pc_write     = 1'b0;
            hz.ifid_write   = 1'b0;
            hz.idex_write   = 1'b0;
            hz.exmem_write  = 1'b0;
            hz.ctrl_bubble  = 1'b1;
            hz.stall_active = 1'b0;
        end else if (hz.mem_busy) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_write  = 1'b0;
            hz.exmem_write = 1'b0;
        end else if (hz.mem_branch_taken) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_flush  = 1'b1;
            hz.exmem_flush = 1'b1;
            w_state_nxt    = RUN;
            w_rem_nxt      = '0;
        end else if (r_state == LOAD_STALL) begin
            // load_use is deliberately ignored until the stall has drained
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.ctrl_bubble = 1'b1;
            w_rem_nxt      = r_rem - 3'd1;
            if (r_rem == 3'd1) begin
                w_state_nxt = RUN;
            end
        end else if (w_load_use) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.ctrl_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                w_state_nxt = LOAD_STALL;
                w_rem_nxt   = 3'(LOAD_STALL_CYCLES - 1);
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!hz.mem_busy) begin
            if (hz.ctrl_bubble && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (hz.mem_branch_taken && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Randomized check of hazard_sequencer (LOAD_STALL_CYCLES = 1 and 3) against a
// bubble-owed reference model, plus an asynchronous reset in the middle of a stall.
module tb_hazard_sequencer;

    localparam int TB_CNT_W = 2;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    hazard_sequencer_if u_if1 ();
    hazard_sequencer_if u_if3 ();

`ifdef HAZARD_PERF_CNT_EN
    logic [TB_CNT_W-1:0] stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3;
    hazard_sequencer #(.LOAD_STALL_CYCLES(1), .CNT_W(TB_CNT_W)) u_dut1 (
        .clk(clk), .rst(rst), .hz(u_if1.slave), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1));
    hazard_sequencer #(.LOAD_STALL_CYCLES(3), .CNT_W(TB_CNT_W)) u_dut3 (
        .clk(clk), .rst(rst), .hz(u_if3.slave), .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3));
`else
    hazard_sequencer #(.LOAD_STALL_CYCLES(1), .CNT_W(TB_CNT_W)) u_dut1 (
        .clk(clk), .rst(rst), .hz(u_if1.slave));
    hazard_sequencer #(.LOAD_STALL_CYCLES(3), .CNT_W(TB_CNT_W)) u_dut3 (
        .clk(clk), .rst(rst), .hz(u_if3.slave));
`endif

    // {pc, ifid, idex, exmem, bubble, ifid_fl, idex_fl, exmem_fl, stall_active}
    logic [8:0] w_out1, w_out3;
    assign w_out1 = {u_if1.pc_write, u_if1.ifid_write, u_if1.idex_write, u_if1.exmem_write,
                     u_if1.ctrl_bubble, u_if1.ifid_flush, u_if1.idex_flush, u_if1.exmem_flush,
                     u_if1.stall_active};
    assign w_out3 = {u_if3.pc_write, u_if3.ifid_write, u_if3.idex_write, u_if3.exmem_write,
                     u_if3.ctrl_bubble, u_if3.ifid_flush, u_if3.idex_flush, u_if3.exmem_flush,
                     u_if3.stall_active};

    localparam logic [8:0] RST_OUT = 9'b0000_1_000_0;

    // Reference model: bubbles still owed after the current cycle, and counter totals.
    int lsc  [2] = '{1, 3};
    int owed [2] = '{0, 0};
    int scnt [2] = '{0, 0};
    int fcnt [2] = '{0, 0};

    logic [5:0] s_op;
    logic [4:0] s_rs, s_rt, s_exrt;
    logic       s_memrd, s_br, s_busy;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic memrd, input logic [4:0] exrt, input logic br,
                         input logic busy);
        s_op = op; s_rs = rs; s_rt = rt; s_memrd = memrd; s_exrt = exrt; s_br = br; s_busy = busy;
        u_if1.id_opcode = op;  u_if3.id_opcode = op;
        u_if1.id_rs = rs;      u_if3.id_rs = rs;
        u_if1.id_rt = rt;      u_if3.id_rt = rt;
        u_if1.ex_memread = memrd; u_if3.ex_memread = memrd;
        u_if1.ex_rt = exrt;    u_if3.ex_rt = exrt;
        u_if1.mem_branch_taken = br; u_if3.mem_branch_taken = br;
        u_if1.mem_busy = busy; u_if3.mem_busy = busy;
    endtask

    function automatic logic load_use();
        logic uses_rt;
        uses_rt = (s_op == 6'b000000) || (s_op == 6'b101011) || (s_op == 6'b000100);
        return s_memrd && (s_exrt != 5'd0) && ((s_exrt == s_rs) || ((s_exrt == s_rt) && uses_rt));
    endfunction

    function automatic logic [8:0] expect_out(input int k);
        logic st;
        st = (owed[k] > 0);
        if (s_busy)                        return {8'b0000_0_000, st};
        else if (s_br)                     return {8'b1111_0_111, st};
        else if (owed[k] > 0 || load_use()) return {8'b0011_1_000, st};
        else                               return {8'b1111_0_000, st};
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            owed[k] = 0; scnt[k] = 0; fcnt[k] = 0;
        end
    endfunction

    // Called at posedge+1 with inputs driven; checks, advances model, returns at next posedge+1.
    task automatic run_cycle();
        logic [8:0] e;
        #2;
        for (int k = 0; k < 2; k++) begin
            e = expect_out(k);
            check(k == 0 ? "ctl_lsc1" : "ctl_lsc3", {7'd0, (k == 0) ? w_out1 : w_out3}, {7'd0, e});
`ifdef HAZARD_PERF_CNT_EN
            check(k == 0 ? "scnt_lsc1" : "scnt_lsc3",
                  {14'd0, (k == 0) ? stall_cnt1 : stall_cnt3}, 16'(scnt[k]));
            check(k == 0 ? "fcnt_lsc1" : "fcnt_lsc3",
                  {14'd0, (k == 0) ? flush_cnt1 : flush_cnt3}, 16'(fcnt[k]));
`endif
            if (!s_busy) begin
                if (e[4] && scnt[k] < CNT_MAX) scnt[k]++;
                if (s_br && fcnt[k] < CNT_MAX) fcnt[k]++;
                if (s_br)              owed[k] = 0;
                else if (owed[k] > 0)  owed[k]--;
                else if (load_use())   owed[k] = lsc[k] - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] small_reg();
        return 5'($urandom_range(0, 3));
    endfunction

    function automatic logic [5:0] rand_op();
        logic [5:0] ops [5];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000};
        return ops[$urandom_range(0, 4)];
    endfunction

    initial begin
        drive(6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #2;
        check("rst_out_lsc1", {7'd0, w_out1}, {7'd0, RST_OUT});
        check("rst_out_lsc3", {7'd0, w_out3}, {7'd0, RST_OUT});
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed: held hazard, then ex_rt = 0, then LW using rt only.
        drive(6'b000000, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0);
        repeat (4) run_cycle();
        drive(6'b000000, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        run_cycle();
        drive(6'b100011, 5'd2, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
        run_cycle();

        // Directed: busy for 4 cycles inside a stall, then branch inside a stall.
        drive(6'b000000, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0);
        run_cycle();
        drive(6'b000000, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b1);
        repeat (4) run_cycle();
        drive(6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (3) run_cycle();
        drive(6'b000000, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0);
        run_cycle();
        drive(6'b000000, 5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0);
        run_cycle();
        drive(6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (2) run_cycle();

        for (int i = 0; i < 400; i++) begin
            drive(rand_op(), small_reg(), small_reg(), 1'($urandom_range(0, 1)), small_reg(),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
            run_cycle();
        end

        // Asynchronous reset between edges while the LSC=3 instance is stalled.
        drive(6'b000000, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0);
        run_cycle();
        check("pre_rst_stall", {15'd0, u_if3.stall_active}, 16'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_lsc1", {7'd0, w_out1}, {7'd0, RST_OUT});
        check("async_rst_lsc3", {7'd0, w_out3}, {7'd0, RST_OUT});
`ifdef HAZARD_PERF_CNT_EN
        check("async_rst_scnt", {14'd0, stall_cnt3}, 16'd0);
        check("async_rst_fcnt", {14'd0, flush_cnt3}, 16'd0);
`endif
        model_reset();
        drive(6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) run_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
